gpio_input: RTL and testbench
=============================

# gpio_input

Memory-mapped input peripheral that sits on the same data-memory bus as the LED/seven-segment output GPIO and shares its 12-bit address space. It synchronises the slide switches, synchronises and debounces the push buttons, and latches button-press events in a sticky edge-capture register. A maskable interrupt line is raised so software can react to presses and then drive the LEDs and HEX displays. All of its registers occupy offsets the output GPIO does not decode, so both blocks can share one chip select.

## Interface

**Parameters**

- `DEBOUNCE_CYCLES`, default 50000: number of consecutive cycles a synchronised key must differ from its stable value before the stable value changes. Legal range is 2..2^20.

**Ports**

- `clk`, input, 1: system clock. Everything is on the rising edge.
- `rst`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `CS`, input, 1: peripheral chip select.
- `REN`, input, 1: read enable, qualified by `CS`.
- `WEN`, input, 1: write enable, qualified by `CS`.
- `Addr`, input, 12: byte offset of the register.
- `DataIn`, input, 32: write data.
- `DataOut`, output, 32: registered read data.
- `KEY`, input, 4: raw push buttons, active-low (0 = pressed), asynchronous.
- `SW`, input, 10: raw slide switches, asynchronous.
- `IRQ`, output, 1: registered interrupt request, active-high.

## Operation

**Register map** (any other offset reads 0; writes to it are ignored)

- `0x000` SW, read-only: bits [9:0] are the synchronised switches; upper bits read 0.
- `0x004` KEYS, read-only: bits [3:0] are the debounced key state, 1 = pressed.
- `0x024` EDGE, read / write-1-to-clear: bits [3:0] are the sticky press flags.
- `0x028` MASK, read/write: bits [3:0] are the interrupt enables.

**Input path**

- Every `KEY` and `SW` bit goes through a two-flop synchroniser.
- `KEY` is inverted after synchronisation.

**Debounce** (one counter per key, 20 bits)

- If the synchronised value equals the stable value, the counter is cleared.
- Otherwise the counter increments.
- When the counter equals `DEBOUNCE_CYCLES-1` and a mismatch is still present:
  - the stable value takes the synchronised value;
  - the counter clears.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches the stable value.

**Edge capture**

- `EDGE[i]` is set on the same edge that stable key `i` goes 0→1 (a press).
- Releases do not set `EDGE`.
- A write with `DataIn[i]=1` to `0x024` clears `EDGE[i]`.
- If a set and a clear of the same bit happen in the same cycle, the set wins and the bit stays 1.

**Bus behaviour**

- Write: takes effect when `CS & WEN` is high at the rising edge. Only `DataIn[3:0]` is used for the writable registers.
- Read: when `CS & REN` is high, `DataOut` takes the selected register value at that edge. In every other cycle `DataOut` takes 0.
- If `REN` and `WEN` are both high with `CS`, both happen. The read returns the value from before the write.

**Interrupt**

- `IRQ` takes `|(EDGE & MASK)` every cycle. It is a level signal and stays high until the flags are cleared or masked.

## Timing

**Reset**, when `rst`=0 at an edge:

- `DataOut`=0 and `IRQ`=0.
- `EDGE`=0 and `MASK`=0.
- Stable keys are 0 (released) and the debounce counters are 0.
- Synchroniser flops for `KEY` go to 1; synchroniser flops for `SW` go to 0.
- Reset during a debounce count abandons the count. No edge is produced.

**Latencies**

- `SW` change to a visible value in the SW register: 2 edges.
- `KEY` press held steady to stable `KEYS` and the `EDGE` bit set: 2 + `DEBOUNCE_CYCLES` edges.
- `EDGE`/`MASK` change to `IRQ`: 1 edge.
- Read request to `DataOut` valid: 1 edge, i.e. valid in the cycle after `CS & REN`.

## Test plan

- **Reset:** hold `rst`=0 for 3 cycles with `KEY`=4'hF and `SW`=10'h155 → `DataOut`=0, `IRQ`=0. After release, a read of `0x000` at cycle 3 or later returns 32'h155.
- **Debounce accept:** with `DEBOUNCE_CYCLES`=8, drive `KEY[0]`=0 and hold → `KEYS` reads 4'h1 and `EDGE` reads 4'h1 exactly 10 edges after the change, never earlier.
- **Glitch reject:** with `DEBOUNCE_CYCLES`=8, pulse `KEY[2]` low for 7 cycles → `KEYS` and `EDGE` stay 0. A 1-cycle release in the middle of a 12-cycle press restarts the count.
- **W1C and interrupt:**
  - Set `MASK`=4'h1 and press `KEY[0]` → `IRQ`=1 one edge after `EDGE[0]` is set.
  - Write 4'h1 to `0x024` → `EDGE`=0 and `IRQ`=0 one edge later.
  - Write 4'h1 to `0x024` on the exact edge a new press sets `EDGE[0]` → `EDGE[0]` stays 1.
- **Release:** release a debounced key → `KEYS` bit returns to 0 after 2 + `DEBOUNCE_CYCLES` edges, and `EDGE` is unchanged.
- **Address decode:** read `0x008`, `0x00C` and `0xFFC` → `DataOut`=0. Writes to these offsets leave `MASK` and `EDGE` unchanged. `DataOut` returns to 0 the cycle after `REN` drops.

Source files
------------

// File: rtl/gpio_input.sv
// gpio_input: memory-mapped switch/key input peripheral.
// Synchronises SW and KEY, debounces the keys, latches key presses in a
// sticky write-1-to-clear EDGE register and raises a maskable level IRQ.
// Register offsets are chosen so the block can share a chip select with
// the LED/HEX output GPIO.
module gpio_input #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CS,
  input  logic        REN,
  input  logic        WEN,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic        IRQ
);

  localparam logic [11:0] ADDR_SW   = 12'h000;
  localparam logic [11:0] ADDR_KEYS = 12'h004;
  localparam logic [11:0] ADDR_EDGE = 12'h024;
  localparam logic [11:0] ADDR_MASK = 12'h028;

  // Terminal count: the stable value flips on the edge where the counter
  // has already seen DEBOUNCE_CYCLES-1 mismatching cycles and one more.
  localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

  // Synchroniser stages. KEY idles high (released), so its flops reset to 1.
  logic [3:0]  r_key_s1, r_key_s2;
  logic [9:0]  r_sw_s1, r_sw_s2;

  // Debounce state.
  logic [3:0]  r_key_stable;
  logic [19:0] r_cnt [4];

  // Software-visible state.
  logic [3:0]  r_edge;
  logic [3:0]  r_mask;
  logic [31:0] r_data_out;
  logic        r_irq;

  // Combinational helpers.
  logic [3:0]  w_key_sync;
  logic [3:0]  w_stable_nxt;
  logic [19:0] w_cnt_nxt [4];
  logic [3:0]  w_press;
  logic [3:0]  w_edge_clr;
  logic [3:0]  w_edge_nxt;
  logic        w_rd;
  logic        w_wr;
  logic [31:0] w_rdata;

  // Keys are active-low on the pins; internally 1 means pressed.
  assign w_key_sync = ~r_key_s2;

  assign w_rd = CS & REN;
  assign w_wr = CS & WEN;

  // Two-flop synchronisers for the asynchronous button and switch inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_key_s1 <= 4'hF;
      r_key_s2 <= 4'hF;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_key_s1 <= KEY;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Per-key debounce: count consecutive mismatch cycles, accept the new
  // level at the terminal count, restart on any match.
  // NOTE: every output of this block gets a default before the branches,
  // otherwise an untaken path would infer a latch.
  always_comb begin
    w_stable_nxt = r_key_stable;
    for (int i = 0; i < 4; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_key_sync[i] != r_key_stable[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_stable_nxt[i] = w_key_sync[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 20'd1;
        end
      end
    end
  end

  // Debounce counters and stable key levels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_key_stable <= '0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_key_stable <= w_stable_nxt;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Press detection and sticky-flag update; a press beats a same-cycle clear.
  always_comb begin
    w_press    = w_stable_nxt & ~r_key_stable;
    w_edge_clr = (w_wr && (Addr == ADDR_EDGE)) ? DataIn[3:0] : 4'h0;
    w_edge_nxt = (r_edge & ~w_edge_clr) | w_press;
  end

  // Read mux over the current (pre-write) register values.
  always_comb begin
    w_rdata = '0;
    unique case (Addr)
      ADDR_SW:   w_rdata[9:0] = r_sw_s2;
      ADDR_KEYS: w_rdata[3:0] = r_key_stable;
      ADDR_EDGE: w_rdata[3:0] = r_edge;
      ADDR_MASK: w_rdata[3:0] = r_mask;
      default:   w_rdata      = '0;
    endcase
  end

  // Bus-visible registers: EDGE, MASK, read data and the interrupt line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_edge     <= '0;
      r_mask     <= '0;
      r_data_out <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_edge <= w_edge_nxt;
      if (w_wr && (Addr == ADDR_MASK)) begin
        r_mask <= DataIn[3:0];
      end
      r_data_out <= w_rd ? w_rdata : 32'h0;
      r_irq      <= |(r_edge & r_mask);
    end
  end

  assign DataOut = r_data_out;
  assign IRQ     = r_irq;

endmodule

// File: tb/tb_gpio_input.sv
// Directed testbench for gpio_input with DEBOUNCE_CYCLES = 8.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_gpio_input;

  logic        clk = 1'b0;
  logic        rst;
  logic        CS, REN, WEN;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic        IRQ;

  int total = 0;
  int bad   = 0;
  logic [31:0] rdata;

  gpio_input #(.DEBOUNCE_CYCLES(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .CS      (CS),
    .REN     (REN),
    .WEN     (WEN),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .KEY     (KEY),
    .SW      (SW),
    .IRQ     (IRQ)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    CS = 1'b1; REN = 1'b1; Addr = a;
    cyc();
    d = DataOut;
    CS = 1'b0; REN = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    CS = 1'b1; WEN = 1'b1; Addr = a; DataIn = d;
    cyc();
    CS = 1'b0; WEN = 1'b0; DataIn = '0;
  endtask

  initial begin
    rst = 1'b0; CS = 1'b0; REN = 1'b0; WEN = 1'b0;
    Addr = '0; DataIn = '0; KEY = 4'hF; SW = 10'h155;

    // Reset held for three cycles.
    repeat (3) cyc();
    chk("rst_dataout", DataOut, 32'h0);
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    rst = 1'b1;
    repeat (3) cyc();
    rd(12'h000, rdata); chk("sw_after_rst", rdata, 32'h155);
    rd(12'h004, rdata); chk("keys_after_rst", rdata, 32'h0);
    rd(12'h024, rdata); chk("edge_after_rst", rdata, 32'h0);
    rd(12'h028, rdata); chk("mask_after_rst", rdata, 32'h0);

    // Switch latency: new value visible in DataOut after the third edge of a
    // continuous read (2 sync edges + 1 read register).
    CS = 1'b1; REN = 1'b1; Addr = 12'h000; SW = 10'h2AA;
    cyc(); chk("sw_lat1", DataOut, 32'h155);
    cyc(); chk("sw_lat2", DataOut, 32'h155);
    cyc(); chk("sw_lat3", DataOut, 32'h2AA);
    CS = 1'b0; REN = 1'b0;
    cyc();

    // Debounce accept: KEYS becomes 1 on edge 10, seen in DataOut on edge 11.
    CS = 1'b1; REN = 1'b1; Addr = 12'h004; KEY = 4'hE;
    for (int n = 1; n <= 10; n++) begin
      cyc(); chk($sformatf("keys_early_%0d", n), DataOut, 32'h0);
    end
    cyc(); chk("keys_accept", DataOut, 32'h1);
    Addr = 12'h024;
    cyc(); chk("edge_set", DataOut, 32'h1);
    REN = 1'b0;
    cyc(); chk("dataout_idle", DataOut, 32'h0);
    CS = 1'b0;
    chk("irq_masked", {31'h0, IRQ}, 32'h0);

    // Release: KEYS clears after 10 edges, EDGE is untouched.
    CS = 1'b1; REN = 1'b1; Addr = 12'h004; KEY = 4'hF;
    for (int n = 1; n <= 10; n++) begin
      cyc(); chk($sformatf("keys_hold_%0d", n), DataOut, 32'h1);
    end
    cyc(); chk("keys_release", DataOut, 32'h0);
    CS = 1'b0; REN = 1'b0;
    rd(12'h024, rdata); chk("edge_after_release", rdata, 32'h1);

    // MASK write, IRQ one edge later; W1C, IRQ drops one edge later.
    wr(12'h028, 32'h1);
    chk("irq_before_mask", {31'h0, IRQ}, 32'h0);
    cyc(); chk("irq_on", {31'h0, IRQ}, 32'h1);
    wr(12'h024, 32'h1);
    chk("irq_still_on", {31'h0, IRQ}, 32'h1);
    cyc(); chk("irq_off", {31'h0, IRQ}, 32'h0);
    rd(12'h024, rdata); chk("edge_cleared", rdata, 32'h0);

    // Clear lands on the same edge a new press sets EDGE[0]: set wins.
    KEY = 4'hE;
    repeat (9) cyc();
    wr(12'h024, 32'h1);
    chk("irq_same_edge", {31'h0, IRQ}, 32'h0);
    cyc(); chk("irq_after_set", {31'h0, IRQ}, 32'h1);
    rd(12'h024, rdata); chk("edge_set_wins", rdata, 32'h1);

    // Glitch reject on KEY[2]: 7-cycle pulse, then 6/1/6 with a release gap.
    wr(12'h024, 32'hF);
    KEY = 4'hA; repeat (7) cyc();
    KEY = 4'hE; repeat (12) cyc();
    rd(12'h004, rdata); chk("glitch_keys", rdata, 32'h1);
    rd(12'h024, rdata); chk("glitch_edge", rdata, 32'h0);
    KEY = 4'hA; repeat (6) cyc();
    KEY = 4'hE; cyc();
    KEY = 4'hA; repeat (6) cyc();
    KEY = 4'hE; repeat (12) cyc();
    rd(12'h004, rdata); chk("restart_keys", rdata, 32'h1);
    rd(12'h024, rdata); chk("restart_edge", rdata, 32'h0);
    // A steady press of KEY[2] is then accepted on edge 10.
    KEY = 4'hA; repeat (10) cyc();
    rd(12'h004, rdata); chk("long_keys", rdata, 32'h5);
    rd(12'h024, rdata); chk("long_edge", rdata, 32'h4);

    // Address decode: unmapped offsets read 0 and ignore writes.
    wr(12'h008, 32'hF);
    wr(12'h00C, 32'hF);
    wr(12'hFFC, 32'hF);
    rd(12'h028, rdata); chk("mask_kept", rdata, 32'h1);
    rd(12'h024, rdata); chk("edge_kept", rdata, 32'h4);
    rd(12'h008, rdata); chk("rd_008", rdata, 32'h0);
    rd(12'h00C, rdata); chk("rd_00c", rdata, 32'h0);
    rd(12'hFFC, rdata); chk("rd_ffc", rdata, 32'h0);
    chk("irq_bit2_masked", {31'h0, IRQ}, 32'h0);

    // Simultaneous read and write returns the pre-write value.
    CS = 1'b1; REN = 1'b1; WEN = 1'b1; Addr = 12'h028; DataIn = 32'hF;
    cyc(); chk("rw_old_value", DataOut, 32'h1);
    CS = 1'b0; REN = 1'b0; WEN = 1'b0; DataIn = '0;
    rd(12'h028, rdata); chk("rw_new_value", rdata, 32'hF);
    chk("irq_bit2_enabled", {31'h0, IRQ}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
